// File: rtl/hdr_det_pkg.sv
// Shared state encoding and default preamble words for the preamble/frame detector.
package hdr_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXP1,
    EXP0,
    PAYLOAD
  } state_t;

  localparam logic [7:0] DEF_PAT0 = 8'h55;
  localparam logic [7:0] DEF_PAT1 = 8'hD5;

endpackage

// File: rtl/pattern_pair_counter.sv
// Counts completed PAT0/PAT1 pairs while the detector walks EXP1/EXP0, saturating at REP_MIN.
module pattern_pair_counter
  import hdr_det_pkg::*;
#(
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   PAT0    = DW'(DEF_PAT0),
  parameter logic [DW-1:0]   PAT1    = DW'(DEF_PAT1),
  parameter int              REP_MIN = 5,
  parameter int              PW      = $clog2(REP_MIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  state_t        state,
  input  logic          frame_end,
  output logic [PW-1:0] pair_cnt,
  output logic          pair_full
);

  assign pair_full = (pair_cnt == PW'(REP_MIN));

  // The count survives into PAYLOAD and is only cleared when the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
    end else if (din_vld) begin
      case (state)
        IDLE: pair_cnt <= '0;
        EXP1: begin
          if (din == PAT1)
            pair_cnt <= pair_full ? pair_cnt : pair_cnt + PW'(1);
          else
            pair_cnt <= '0;
        end
        EXP0: begin
          if (din != PAT0 && !pair_full)
            pair_cnt <= '0;
        end
        PAYLOAD: begin
          if (frame_end)
            pair_cnt <= '0;
        end
        default: pair_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/preamble_frame_detect.sv
// Detects a repeated PAT0/PAT1 preamble and forwards the following fixed-length
// payload with sof/eof framing, header/error pulses and a frame counter.
module preamble_frame_detect
  import hdr_det_pkg::*;
#(
  parameter int            DW        = 8,
  parameter logic [DW-1:0] PAT0      = DW'(DEF_PAT0),
  parameter logic [DW-1:0] PAT1      = DW'(DEF_PAT1),
  parameter int            REP_MIN   = 5,
  parameter int            FRAME_LEN = 16,
  parameter int            FCNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DW-1:0]                  din,
  input  logic                           din_vld,
  output logic [DW-1:0]                  dout,
  output logic                           dout_vld,
  output logic                           dout_sof,
  output logic                           dout_eof,
  output logic                           hdr_det,
  output logic                           hdr_err,
  output logic                           locked,
  output logic [$clog2(REP_MIN+1)-1:0]   pair_cnt,
  output logic [FCNT_W-1:0]              frame_cnt
);

  localparam int PW    = $clog2(REP_MIN + 1);
  localparam int PAY_W = $clog2(FRAME_LEN);

  state_t           state;
  logic [PAY_W-1:0] pay_cnt;
  logic             pair_full;
  logic             frame_end;

  assign frame_end = (state == PAYLOAD) && (pay_cnt == PAY_W'(FRAME_LEN - 1));

  pattern_pair_counter #(
    .DW      (DW),
    .PAT0    (PAT0),
    .PAT1    (PAT1),
    .REP_MIN (REP_MIN),
    .PW      (PW)
  ) u_pair_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .state     (state),
    .frame_end (frame_end),
    .pair_cnt  (pair_cnt),
    .pair_full (pair_full)
  );

  // locked follows the state one cycle late so the eof word still shows locked=1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pay_cnt   <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sof  <= 1'b0;
      dout_eof  <= 1'b0;
      hdr_det   <= 1'b0;
      hdr_err   <= 1'b0;
      locked    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dout_vld <= 1'b0;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      hdr_det  <= 1'b0;
      hdr_err  <= 1'b0;
      locked   <= (state == PAYLOAD);
      if (din_vld) begin
        case (state)
          IDLE: begin
            if (din == PAT0)
              state <= EXP1;
          end
          EXP1: begin
            if (din == PAT1) begin
              state <= EXP0;
            end else if (din != PAT0) begin
              state   <= IDLE;
              hdr_err <= pair_full;
            end
          end
          EXP0: begin
            if (din == PAT0) begin
              state <= EXP1;
            end else if (pair_full) begin
              state    <= PAYLOAD;
              hdr_det  <= 1'b1;
              locked   <= 1'b1;
              dout     <= din;
              dout_vld <= 1'b1;
              dout_sof <= 1'b1;
              pay_cnt  <= PAY_W'(1);
            end else begin
              state <= IDLE;
            end
          end
          PAYLOAD: begin
            dout     <= din;
            dout_vld <= 1'b1;
            if (frame_end) begin
              dout_eof  <= 1'b1;
              frame_cnt <= frame_cnt + FCNT_W'(1);
              pay_cnt   <= '0;
              state     <= IDLE;
            end else begin
              pay_cnt <= pay_cnt + PAY_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_preamble_frame_detect.sv
// Scoreboard bench for preamble_frame_detect: stimulus pushes expected output events,
// a negedge monitor pops and compares them whenever the DUT presents an event.
module tb_preamble_frame_detect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_vld;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_sof;
  logic        dout_eof;
  logic        hdr_det;
  logic        hdr_err;
  logic        locked;
  logic [2:0]  pair_cnt;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [7:0]  dout;
    logic        vld;
    logic        sof;
    logic        eof;
    logic        det;
    logic        err;
    logic        locked;
    logic [15:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  preamble_frame_detect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_sof  (dout_sof),
    .dout_eof  (dout_eof),
    .hdr_det   (hdr_det),
    .hdr_err   (hdr_err),
    .locked    (locked),
    .pair_cnt  (pair_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v);
    din     = d;
    din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sendPairs(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'hD5, 1'b1);
    end
  endtask

  task automatic expectWord(input logic [7:0] d, input logic sof, input logic eof,
                            input logic [15:0] fc);
    exp_t e;
    e.dout = d; e.vld = 1'b1; e.sof = sof; e.eof = eof;
    e.det = sof; e.err = 1'b0; e.locked = 1'b1; e.fcnt = fc;
    exp_q.push_back(e);
  endtask

  task automatic expectErr(input logic [15:0] fc);
    exp_t e;
    e.dout = 8'h00; e.vld = 1'b0; e.sof = 1'b0; e.eof = 1'b0;
    e.det = 1'b0; e.err = 1'b1; e.locked = 1'b0; e.fcnt = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: every output event must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && (dout_vld || hdr_det || hdr_err)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_event: got vld=%0b det=%0b err=%0b dout=%0h, expected no event",
                 dout_vld, hdr_det, hdr_err, dout);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("ev_vld", 32'(dout_vld), 32'(mon_e.vld));
        if (mon_e.vld) checkOutput("ev_dout", 32'(dout), 32'(mon_e.dout));
        checkOutput("ev_sof", 32'(dout_sof), 32'(mon_e.sof));
        checkOutput("ev_eof", 32'(dout_eof), 32'(mon_e.eof));
        checkOutput("ev_det", 32'(hdr_det), 32'(mon_e.det));
        checkOutput("ev_err", 32'(hdr_err), 32'(mon_e.err));
        checkOutput("ev_locked", 32'(locked), 32'(mon_e.locked));
        checkOutput("ev_fcnt", 32'(frame_cnt), 32'(mon_e.fcnt));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_vld", 32'(dout_vld), 32'd0);
    checkOutput("rst_det", 32'(hdr_det), 32'd0);
    checkOutput("rst_err", 32'(hdr_err), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_pair", 32'(pair_cnt), 32'd0);
    checkOutput("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;

    // Basic frame after idle traffic
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b1);
    sendPairs(5);
    checkOutput("t1_pair5", 32'(pair_cnt), 32'd5);
    checkOutput("t1_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 16; i++) begin
      expectWord(8'(i), i == 0, i == 15, (i == 15) ? 16'd1 : 16'd0);
      applyStimulus(8'(i), 1'b1);
    end
    checkOutput("t1_locked_eof", 32'(locked), 32'd1);
    checkOutput("t1_fcnt", 32'(frame_cnt), 32'd1);
    checkOutput("t1_pair_clr", 32'(pair_cnt), 32'd0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("t1_unlock_after", 32'(locked), 32'd0);

    // Too few pairs
    sendPairs(2);
    checkOutput("t2_pair2", 32'(pair_cnt), 32'd2);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t2_pair_back0", 32'(pair_cnt), 32'd0);

    // Wrong pattern never counts
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'h56, 1'b1);
      applyStimulus(8'hD6, 1'b1);
    end
    checkOutput("t3_pair0", 32'(pair_cnt), 32'd0);
    checkOutput("t3_unlocked", 32'(locked), 32'd0);

    // Armed preamble broken mid-pair
    sendPairs(5);
    applyStimulus(8'h55, 1'b1);
    checkOutput("t4_pair_armed", 32'(pair_cnt), 32'd5);
    expectErr(16'd1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t4_pair_clr", 32'(pair_cnt), 32'd0);
    applyStimulus(8'h00, 1'b1);

    // Seven pairs and a payload with a stall after every word
    for (int k = 0; k < 7; k++) begin
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'hD5, 1'b1);
      applyStimulus(8'h55, 1'b0);
    end
    checkOutput("t5_pair_sat", 32'(pair_cnt), 32'd5);
    for (int i = 0; i < 16; i++) begin
      expectWord(8'(i), i == 0, i == 15, (i == 15) ? 16'd2 : 16'd1);
      applyStimulus(8'(i), 1'b1);
      applyStimulus(8'hAA, 1'b0);
      if (i == 3 || i == 9) begin
        checkOutput("t5_hold_dout", 32'(dout), 32'(i));
        checkOutput("t5_hold_vld", 32'(dout_vld), 32'd0);
        checkOutput("t5_hold_locked", 32'(locked), 32'd1);
      end
    end
    checkOutput("t5_fcnt", 32'(frame_cnt), 32'd2);
    checkOutput("t5_unlocked", 32'(locked), 32'd0);

    // Reset in the middle of the payload
    sendPairs(5);
    for (int i = 0; i < 8; i++) begin
      expectWord(8'(i), i == 0, 1'b0, 16'd2);
      applyStimulus(8'(i), 1'b1);
    end
    din = 8'h08;
    din_vld = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_dout", 32'(dout), 32'd0);
    checkOutput("t6_rst_vld", 32'(dout_vld), 32'd0);
    checkOutput("t6_rst_eof", 32'(dout_eof), 32'd0);
    checkOutput("t6_rst_locked", 32'(locked), 32'd0);
    checkOutput("t6_rst_pair", 32'(pair_cnt), 32'd0);
    checkOutput("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    din_vld = 1'b0;
    rst_n = 1'b1;
    sendPairs(5);
    for (int i = 0; i < 16; i++) begin
      expectWord(8'(8'h80 + i), i == 0, i == 15, (i == 15) ? 16'd1 : 16'd0);
      applyStimulus(8'(8'h80 + i), 1'b1);
    end
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("t6_fcnt", 32'(frame_cnt), 32'd1);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
